// File: rtl/fp_addsub_ctrl_pipe_if.sv
// Handshake and data bundle for the FP add/subtract control pipeline.
// The master side drives operands, sums and the downstream ready signals.
// The slave side is the control unit.
interface fp_addsub_ctrl_pipe_if #(
    parameter int EXPO_WIDTH = 8,
    parameter int MENT_WIDTH = 23,
    parameter int DATA_WIDTH = 1 + EXPO_WIDTH + MENT_WIDTH,
    parameter int SH_W       = $clog2(MENT_WIDTH + 4),
    parameter int LZ_W       = $clog2(MENT_WIDTH + 2)
);
    // operand path
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_WIDTH-1:0]   a_in;
    logic [DATA_WIDTH-1:0]   b_in;
    logic                    opcode_in;
    logic                    ctl_valid;
    logic                    ctl_ready;
    logic                    swap_out;
    logic [SH_W-1:0]         rshift_out;
    logic                    eff_sub_out;
    logic                    sign_out;
    logic                    zero_out;
    // normalisation path
    logic                    sum_valid;
    logic                    sum_ready;
    logic [MENT_WIDTH+1:0]   sum_in;
    logic                    norm_valid;
    logic                    norm_ready;
    logic                    norm_right_out;
    logic [LZ_W-1:0]         lz_out;
    logic                    sum_zero_out;

    modport master (
        output in_valid, a_in, b_in, opcode_in, ctl_ready,
        output sum_valid, sum_in, norm_ready,
        input  in_ready, ctl_valid, swap_out, rshift_out, eff_sub_out, sign_out, zero_out,
        input  sum_ready, norm_valid, norm_right_out, lz_out, sum_zero_out
    );

    modport slave (
        input  in_valid, a_in, b_in, opcode_in, ctl_ready,
        input  sum_valid, sum_in, norm_ready,
        output in_ready, ctl_valid, swap_out, rshift_out, eff_sub_out, sign_out, zero_out,
        output sum_ready, norm_valid, norm_right_out, lz_out, sum_zero_out
    );
endinterface

// File: rtl/fp_addsub_ctrl_pipe.sv
// Pipelined control unit for the FP add/subtract datapath.
// The operand path has two stages, S1 and S2. It produces swap, alignment
// shift, effective operation, result sign and an exact-zero flag.
// The independent one-stage norm path turns a raw mantissa sum into a
// normalisation shift.
module fp_addsub_ctrl_pipe #(
    parameter int EXPO_WIDTH = 8,
    parameter int MENT_WIDTH = 23,
    parameter int DATA_WIDTH = 1 + EXPO_WIDTH + MENT_WIDTH,
    parameter int SH_W       = $clog2(MENT_WIDTH + 4),
    parameter int LZ_W       = $clog2(MENT_WIDTH + 2)
) (
    input logic clk,
    input logic rst,
    fp_addsub_ctrl_pipe_if.slave bus
);
    localparam int unsigned SAT = MENT_WIDTH + 3;

    // operand field extraction, layout {sign, exp, frac}
    logic                  a_sign, b_sign;
    logic [EXPO_WIDTH-1:0] a_exp, b_exp;
    logic [MENT_WIDTH-1:0] a_frac, b_frac;

    assign a_sign = bus.a_in[DATA_WIDTH-1];
    assign b_sign = bus.b_in[DATA_WIDTH-1];
    assign a_exp  = bus.a_in[DATA_WIDTH-2 -: EXPO_WIDTH];
    assign b_exp  = bus.b_in[DATA_WIDTH-2 -: EXPO_WIDTH];
    assign a_frac = bus.a_in[MENT_WIDTH-1:0];
    assign b_frac = bus.b_in[MENT_WIDTH-1:0];

    // Ready is held low for the first cycle after reset. It then rises once reset is released.
    logic active_reg;

    // Track whether the unit has left reset.
    always_ff @(posedge clk) begin
        if (rst) active_reg <= 1'b0;
        else     active_reg <= 1'b1;
    end

    // ---------------- operand path ----------------
    logic                  s1_valid_reg;
    logic [EXPO_WIDTH:0]   s1_diff_reg;
    logic                  s1_sign_a_reg, s1_sign_b_reg, s1_op_reg;
    logic                  s1_frac_gt_reg, s1_frac_eq_reg;

    logic                  s2_valid_reg;
    logic                  swap_reg, eff_sub_reg, sign_reg, zero_reg;
    logic [SH_W-1:0]       rshift_reg;

    logic s2_load, s1_load, in_ready_int;

    // A stage loads when it is empty or when its content leaves this cycle.
    // The ready signals therefore depend only on the downstream ready inputs.
    assign s2_load      = !s2_valid_reg || bus.ctl_ready;
    assign s1_load      = !s1_valid_reg || s2_load;
    assign in_ready_int = active_reg && s1_load;

    // S1: exponent difference plus registered signs, opcode and fraction compares.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg   <= 1'b0;
            s1_diff_reg    <= '0;
            s1_sign_a_reg  <= 1'b0;
            s1_sign_b_reg  <= 1'b0;
            s1_op_reg      <= 1'b0;
            s1_frac_gt_reg <= 1'b0;
            s1_frac_eq_reg <= 1'b0;
        end else if (s1_load) begin
            s1_valid_reg   <= bus.in_valid && in_ready_int;
            s1_diff_reg    <= {1'b0, a_exp} - {1'b0, b_exp};
            s1_sign_a_reg  <= a_sign;
            s1_sign_b_reg  <= b_sign;
            s1_op_reg      <= bus.opcode_in;
            s1_frac_gt_reg <= a_frac > b_frac;
            s1_frac_eq_reg <= a_frac == b_frac;
        end
    end

    // S2 decode from the S1 registers
    logic                diff_neg, diff_zero;
    logic [EXPO_WIDTH:0] abs_diff;
    logic                swap_c, eff_sub_c, zero_c, sign_c;
    logic [SH_W-1:0]     rshift_c;

    assign diff_neg  = s1_diff_reg[EXPO_WIDTH];
    assign diff_zero = (s1_diff_reg == '0);
    assign abs_diff  = diff_neg ? -s1_diff_reg : s1_diff_reg;
    // Shifting by more than MENT_WIDTH+3 only pushes sticky zeros.
    // The shift is therefore clamped there.
    assign rshift_c  = (32'(abs_diff) > SAT) ? SH_W'(SAT) : SH_W'(abs_diff);
    assign swap_c    = diff_neg || (diff_zero && !s1_frac_gt_reg && !s1_frac_eq_reg);
    assign eff_sub_c = s1_op_reg ^ s1_sign_a_reg ^ s1_sign_b_reg;
    assign zero_c    = eff_sub_c && diff_zero && s1_frac_eq_reg;
    assign sign_c    = zero_c ? 1'b0 : (swap_c ? (s1_sign_b_reg ^ s1_op_reg) : s1_sign_a_reg);

    // S2: register the control word, holding it while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_reg <= 1'b0;
            swap_reg     <= 1'b0;
            rshift_reg   <= '0;
            eff_sub_reg  <= 1'b0;
            sign_reg     <= 1'b0;
            zero_reg     <= 1'b0;
        end else if (s2_load) begin
            s2_valid_reg <= s1_valid_reg;
            swap_reg     <= swap_c;
            rshift_reg   <= rshift_c;
            eff_sub_reg  <= eff_sub_c;
            sign_reg     <= sign_c;
            zero_reg     <= zero_c;
        end
    end

    assign bus.in_ready    = in_ready_int;
    assign bus.ctl_valid   = s2_valid_reg;
    assign bus.swap_out    = swap_reg;
    assign bus.rshift_out  = rshift_reg;
    assign bus.eff_sub_out = eff_sub_reg;
    assign bus.sign_out    = sign_reg;
    assign bus.zero_out    = zero_reg;

    // ---------------- normalisation path ----------------
    logic            norm_valid_reg, norm_right_reg, sum_zero_reg;
    logic [LZ_W-1:0] lz_reg;
    logic            n_load, sum_ready_int;
    logic            norm_right_c, sum_zero_c;
    logic [LZ_W-1:0] lz_scan, lz_c;

    assign n_load        = !norm_valid_reg || bus.norm_ready;
    assign sum_ready_int = active_reg && n_load;

    // Leading-one search over the hidden bit and the fraction.
    // The highest set bit wins because later iterations override earlier ones.
    always_comb begin
        lz_scan = '0;
        for (int i = 0; i <= MENT_WIDTH; i++) begin
            if (bus.sum_in[i]) lz_scan = LZ_W'(MENT_WIDTH - i);
        end
    end

    assign norm_right_c = bus.sum_in[MENT_WIDTH+1];
    assign sum_zero_c   = (bus.sum_in == '0);
    assign lz_c         = norm_right_c ? '0 : lz_scan;

    // N1: register the normalisation result, holding it while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            norm_valid_reg <= 1'b0;
            norm_right_reg <= 1'b0;
            lz_reg         <= '0;
            sum_zero_reg   <= 1'b0;
        end else if (n_load) begin
            norm_valid_reg <= bus.sum_valid && sum_ready_int;
            norm_right_reg <= norm_right_c;
            lz_reg         <= lz_c;
            sum_zero_reg   <= sum_zero_c;
        end
    end

    assign bus.sum_ready      = sum_ready_int;
    assign bus.norm_valid     = norm_valid_reg;
    assign bus.norm_right_out = norm_right_reg;
    assign bus.lz_out         = lz_reg;
    assign bus.sum_zero_out   = sum_zero_reg;
endmodule

// File: tb/tb_fp_addsub_ctrl_pipe.sv
// Self-checking bench for fp_addsub_ctrl_pipe.
// It uses directed vectors plus random streams checked against a reference model.
// The model is written from the arithmetic rules of the control unit.
module tb_fp_addsub_ctrl_pipe;
    localparam int EW = 8;
    localparam int MW = 23;
    localparam int DW = 1 + EW + MW;
    localparam int SH_W = $clog2(MW + 4);
    localparam int LZ_W = $clog2(MW + 2);
    localparam int BUDGET = 3000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_addsub_ctrl_pipe_if #(.EXPO_WIDTH(EW), .MENT_WIDTH(MW)) bus ();

    fp_addsub_ctrl_pipe #(.EXPO_WIDTH(EW), .MENT_WIDTH(MW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int passes = 0;

    // packed views: {swap, rshift, eff_sub, sign, zero} and {norm_right, lz, sum_zero}
    logic [SH_W+3:0] ctl_word;
    logic [LZ_W+1:0] norm_word;
    assign ctl_word  = {bus.swap_out, bus.rshift_out, bus.eff_sub_out, bus.sign_out, bus.zero_out};
    assign norm_word = {bus.norm_right_out, bus.lz_out, bus.sum_zero_out};

    // Reference: control word from the operands, using integer exponent arithmetic.
    function automatic logic [SH_W+3:0] ref_ctl(logic [DW-1:0] a, logic [DW-1:0] b, logic op);
        int ea, eb, fa, fb, diff, mag;
        logic sw, eff, zr, sg;
        ea   = int'(a[DW-2 -: EW]);
        eb   = int'(b[DW-2 -: EW]);
        fa   = int'(a[MW-1:0]);
        fb   = int'(b[MW-1:0]);
        diff = ea - eb;
        sw   = (diff < 0) || (diff == 0 && fb > fa);
        mag  = (diff < 0) ? -diff : diff;
        if (mag > MW + 3) mag = MW + 3;
        eff  = op ^ a[DW-1] ^ b[DW-1];
        zr   = eff && (diff == 0) && (fa == fb);
        sg   = zr ? 1'b0 : (sw ? (b[DW-1] ^ op) : a[DW-1]);
        return {sw, SH_W'(mag), eff, sg, zr};
    endfunction

    // Reference: normalisation result from floor(log2(sum)).
    function automatic logic [LZ_W+1:0] ref_norm(logic [MW+1:0] s);
        logic [MW+1:0] t;
        int msb;
        if (s == '0)  return {1'b0, LZ_W'(0), 1'b1};
        if (s[MW+1])  return {1'b1, LZ_W'(0), 1'b0};
        t = s;
        msb = 0;
        while (t > 1) begin
            t = t >> 1;
            msb++;
        end
        return {1'b0, LZ_W'(MW - msb), 1'b0};
    endfunction

    function automatic logic [DW-1:0] rand_b(logic [DW-1:0] a);
        logic [DW-1:0] b;
        logic [EW-1:0] e;
        case ($urandom_range(0, 3))
            0: b = $urandom;
            1: b = {1'($urandom_range(0, 1)), a[DW-2 -: EW], MW'($urandom)};
            2: b = {1'($urandom_range(0, 1)), a[DW-2:0]};
            default: begin
                e = a[DW-2 -: EW] ^ EW'($urandom_range(0, 3));
                b = {a[DW-1], e, MW'($urandom)};
            end
        endcase
        return b;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.a_in = '0; bus.b_in = '0; bus.opcode_in = 1'b0;
        bus.ctl_ready = 1'b1; bus.sum_valid = 1'b0; bus.sum_in = '0; bus.norm_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.sum_ready, bus.ctl_valid, bus.norm_valid} !== 4'b0000)
            $display("FAIL reset_valids: got %b want 0000",
                     {bus.in_ready, bus.sum_ready, bus.ctl_valid, bus.norm_valid});
        else passes++;
        checks++;
        if ({ctl_word, norm_word} !== '0)
            $display("FAIL reset_data: got ctl=%h norm=%h want 0", ctl_word, norm_word);
        else passes++;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.sum_ready} !== 2'b11)
            $display("FAIL reset_release_ready: got %b want 11", {bus.in_ready, bus.sum_ready});
        else passes++;
    endtask

    task automatic test_ctl_directed();
        logic [DW-1:0]   ta [4] = '{32'h3FC00000, 32'h3F800000, 32'h40400000, 32'h60000000};
        logic [DW-1:0]   tb [4] = '{32'h3FA00000, 32'h40000000, 32'h40400000, 32'h3F800000};
        logic            top[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [SH_W+3:0] tex[4] = '{{1'b0, 5'd0, 3'b000}, {1'b1, 5'd1, 3'b110},
                                    {1'b0, 5'd0, 3'b101}, {1'b0, 5'd26, 3'b000}};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1; bus.a_in = ta[i]; bus.b_in = tb[i]; bus.opcode_in = top[i];
            bus.ctl_ready = 1'b1;
            #1;
            checks++;
            if (bus.in_ready !== 1'b1) $display("FAIL dir_in_ready[%0d]: got %b want 1", i, bus.in_ready);
            else passes++;
            @(negedge clk);
            bus.in_valid = 1'b0;
            #1;
            checks++;
            if (bus.ctl_valid !== 1'b0) $display("FAIL dir_early_valid[%0d]: got %b want 0", i, bus.ctl_valid);
            else passes++;
            @(negedge clk);
            #1;
            checks++;
            if ({bus.ctl_valid, ctl_word} !== {1'b1, tex[i]})
                $display("FAIL dir_ctl[%0d]: got valid=%b word=%h want valid=1 word=%h",
                         i, bus.ctl_valid, ctl_word, tex[i]);
            else passes++;
            $display("ctl dir %0d a=%h b=%h op=%0d word=%h", i, ta[i], tb[i], top[i], ctl_word);
        end
    endtask

    // Operand stream. Mode 0: back-to-back with ctl_ready low on cycles 2..5.
    // Mode 1: random valid/ready.
    task automatic run_ctl(int n, int mode, string tag);
        logic [SH_W+3:0] q[$];
        logic [DW-1:0]   ca, cb;
        logic            cop;
        logic            have = 1'b0;
        int sent = 0, got = 0, count = 0;
        bit done = 0;
        logic exp_rdy;
        for (int cyc = 0; cyc < BUDGET && !done; cyc++) begin
            @(negedge clk);
            if (!have) begin
                ca = $urandom; cb = rand_b(ca); cop = 1'($urandom_range(0, 1)); have = 1'b1;
            end
            if (mode == 0) begin
                bus.ctl_ready = !(cyc >= 2 && cyc <= 5);
                bus.in_valid  = (sent < n);
            end else begin
                bus.ctl_ready = ($urandom_range(0, 3) != 0);
                bus.in_valid  = (sent < n) && ($urandom_range(0, 3) != 0);
            end
            bus.a_in = ca; bus.b_in = cb; bus.opcode_in = cop;
            #1;
            exp_rdy = (count < 2) || bus.ctl_ready;
            checks++;
            if (bus.in_ready !== exp_rdy)
                $display("FAIL %s_in_ready cyc %0d: got %b want %b", tag, cyc, bus.in_ready, exp_rdy);
            else passes++;
            if (count == 2) begin
                checks++;
                if (bus.ctl_valid !== 1'b1) $display("FAIL %s_full_valid cyc %0d: got %b want 1", tag, cyc, bus.ctl_valid);
                else passes++;
            end
            if (bus.ctl_valid === 1'b1) begin
                checks++;
                if (q.size() == 0) $display("FAIL %s_spurious cyc %0d: got word=%h want no result", tag, cyc, ctl_word);
                else if (ctl_word !== q[0])
                    $display("FAIL %s_ctl[%0d] cyc %0d: got %h want %h", tag, got, cyc, ctl_word, q[0]);
                else passes++;
                if (bus.ctl_ready && q.size() != 0) begin
                    $display("ctl %s %0d word=%h", tag, got, q[0]);
                    void'(q.pop_front());
                    got++;
                    count--;
                end
            end
            if (bus.in_valid && bus.in_ready === 1'b1) begin
                q.push_back(ref_ctl(ca, cb, cop));
                sent++;
                count++;
                have = 1'b0;
            end
            done = (sent == n) && (q.size() == 0);
        end
        bus.in_valid = 1'b0;
        bus.ctl_ready = 1'b1;
        checks++;
        if (!done) $display("FAIL %s_timeout: got %0d results want %0d", tag, got, n);
        else passes++;
    endtask

    task automatic test_norm_directed();
        logic [MW+1:0]   ts [4] = '{25'h1000000, 25'h0800000, 25'h0000001, 25'h0000000};
        logic [LZ_W+1:0] tex[4] = '{{1'b1, 5'd0, 1'b0}, {1'b0, 5'd0, 1'b0},
                                    {1'b0, 5'd23, 1'b0}, {1'b0, 5'd0, 1'b1}};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.sum_valid = 1'b1; bus.sum_in = ts[i]; bus.norm_ready = 1'b1;
            #1;
            checks++;
            if (bus.sum_ready !== 1'b1) $display("FAIL ndir_sum_ready[%0d]: got %b want 1", i, bus.sum_ready);
            else passes++;
            @(negedge clk);
            bus.sum_valid = 1'b0; bus.norm_ready = 1'b0;
            #1;
            checks++;
            if ({bus.norm_valid, norm_word, bus.sum_ready} !== {1'b1, tex[i], 1'b0})
                $display("FAIL ndir_norm[%0d]: got valid=%b word=%h sum_ready=%b want valid=1 word=%h sum_ready=0",
                         i, bus.norm_valid, norm_word, bus.sum_ready, tex[i]);
            else passes++;
            @(negedge clk);
            bus.norm_ready = 1'b1;
            #1;
            checks++;
            if ({bus.norm_valid, norm_word} !== {1'b1, tex[i]})
                $display("FAIL ndir_hold[%0d]: got valid=%b word=%h want valid=1 word=%h",
                         i, bus.norm_valid, norm_word, tex[i]);
            else passes++;
            $display("norm dir %0d sum=%h word=%h", i, ts[i], norm_word);
        end
    endtask

    task automatic run_norm(int n, string tag);
        logic [LZ_W+1:0] q[$];
        logic [MW+1:0]   cs;
        logic            have = 1'b0;
        int sent = 0, got = 0, count = 0;
        bit done = 0;
        logic exp_rdy;
        for (int cyc = 0; cyc < BUDGET && !done; cyc++) begin
            @(negedge clk);
            if (!have) begin
                cs = ($urandom_range(0, 9) == 0) ? '0 : (MW+2)'($urandom) >> $urandom_range(0, MW + 1);
                have = 1'b1;
            end
            bus.norm_ready = ($urandom_range(0, 3) != 0);
            bus.sum_valid  = (sent < n) && ($urandom_range(0, 3) != 0);
            bus.sum_in     = cs;
            #1;
            exp_rdy = (count == 0) || bus.norm_ready;
            checks++;
            if ({bus.sum_ready, bus.norm_valid} !== {exp_rdy, (count == 1)})
                $display("FAIL %s_hs cyc %0d: got ready=%b valid=%b want ready=%b valid=%b",
                         tag, cyc, bus.sum_ready, bus.norm_valid, exp_rdy, (count == 1));
            else passes++;
            if (bus.norm_valid === 1'b1 && q.size() != 0) begin
                checks++;
                if (norm_word !== q[0])
                    $display("FAIL %s_norm[%0d] cyc %0d: got %h want %h", tag, got, cyc, norm_word, q[0]);
                else passes++;
                if (bus.norm_ready) begin
                    $display("norm %s %0d word=%h", tag, got, q[0]);
                    void'(q.pop_front());
                    got++;
                    count--;
                end
            end
            if (bus.sum_valid && bus.sum_ready === 1'b1) begin
                q.push_back(ref_norm(cs));
                sent++;
                count++;
                have = 1'b0;
            end
            done = (sent == n) && (q.size() == 0);
        end
        bus.sum_valid = 1'b0;
        bus.norm_ready = 1'b1;
        checks++;
        if (!done) $display("FAIL %s_timeout: got %0d results want %0d", tag, got, n);
        else passes++;
    endtask

    task automatic test_reset_midflight();
        bus.ctl_ready = 1'b0; bus.norm_ready = 1'b0;
        repeat (2) begin
            @(negedge clk);
            bus.in_valid = 1'b1; bus.a_in = 32'h3F800000; bus.b_in = 32'h40000000; bus.opcode_in = 1'b1;
            bus.sum_valid = 1'b1; bus.sum_in = 25'h0000001;
        end
        @(negedge clk);
        bus.in_valid = 1'b0; bus.sum_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.ctl_valid, bus.norm_valid, bus.in_ready, bus.sum_ready} !== 4'b1100)
            $display("FAIL mid_full: got %b want 1100",
                     {bus.ctl_valid, bus.norm_valid, bus.in_ready, bus.sum_ready});
        else passes++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.ctl_valid, bus.norm_valid, bus.in_ready, bus.sum_ready, ctl_word, norm_word} !== '0)
            $display("FAIL mid_flush: got v=%b%b r=%b%b ctl=%h norm=%h want all 0",
                     bus.ctl_valid, bus.norm_valid, bus.in_ready, bus.sum_ready, ctl_word, norm_word);
        else passes++;
        bus.ctl_ready = 1'b1; bus.norm_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({bus.ctl_valid, bus.norm_valid} !== 2'b00)
                $display("FAIL mid_stale[%0d]: got %b want 00", i, {bus.ctl_valid, bus.norm_valid});
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_ctl_directed();
        run_ctl(6, 0, "stall");
        test_norm_directed();
        run_ctl(120, 1, "rand");
        run_norm(120, "nrand");
        test_reset_midflight();
        test_ctl_directed();
        run_ctl(10, 1, "post");
        run_norm(10, "npost");
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/fp_addsub_ctrl_pipe.md
# fp_addsub_ctrl_pipe

Parametrised, pipelined control unit for the floating-point add/subtract datapath. It accepts two packed operands plus an opcode through a valid/ready handshake and produces the datapath control word two cycles later: swap select, alignment shift, effective operation, result sign and exact-zero flag. A second, independent one-stage path takes the raw mantissa sum from the adder stage and returns the normalisation shift. Both paths apply backpressure, sustain one transaction per cycle, and keep transactions in order.

## Interface
- EXPO_WIDTH, 8, exponent field width
- MENT_WIDTH, 23, stored fraction width
- DATA_WIDTH, 1+EXPO_WIDTH+MENT_WIDTH, packed operand width, layout {sign, exp, frac}
- SH_W (derived), $clog2(MENT_WIDTH+4), width of rshift
- LZ_W (derived), $clog2(MENT_WIDTH+2), width of lz
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  unit can accept operands
- a_in, b_in  in  DATA_WIDTH  operands
- opcode_in  in  1  operation select: 0 = add, 1 = subtract
- ctl_valid  out  1  control word valid
- ctl_ready  in  1  downstream accepts control word
- swap_out  out  1  1 = b is the larger-magnitude operand
- rshift_out  out  SH_W  right-shift amount for the smaller mantissa
- eff_sub_out  out  1  effective mantissa subtraction
- sign_out  out  1  result sign
- zero_out  out  1  exact zero result
- sum_valid  in  1  mantissa sum valid
- sum_ready  out  1  sum accepted
- sum_in  in  MENT_WIDTH+2  sum; bit MENT_WIDTH+1 = carry, bit MENT_WIDTH = hidden
- norm_valid  out  1  normalisation result valid
- norm_ready  in  1  downstream accepts normalisation result
- norm_right_out  out  1  carry set: shift right by 1, exponent +1
- lz_out  out  LZ_W  left-shift count that moves the leading one to bit MENT_WIDTH
- sum_zero_out  out  1  sum is all zeros

## Operation
- Stage S1 (registered):
  - diff = {0,exp_a} − {0,exp_b}, EXPO_WIDTH+1 bits, two's complement.
  - Register signs, opcode, frac_gt = frac_a > frac_b and frac_eq = frac_a == frac_b.
- Stage S2 (registered, drives the ctl outputs):
  - swap = diff<0, or (diff==0 and frac_b>frac_a).
  - rshift = |diff|, saturated to MENT_WIDTH+3.
  - eff_sub = opcode ^ sign_a ^ sign_b.
  - zero = eff_sub and diff==0 and frac_eq.
  - sign = 0 when zero; otherwise (sign_b ^ opcode) when swap; otherwise sign_a.
- Hidden bit is (exp != 0). NaN and Inf are not special-cased; they are handled by the exception unit.
- Norm stage N1 (registered):
  - norm_right = sum[MENT_WIDTH+1].
  - lz = MENT_WIDTH − index of the highest set bit in sum[MENT_WIDTH:0]; forced to 0 when norm_right is set.
  - sum_zero = (sum==0), with lz = 0.
- Pipeline control, applied per stage: a stage loads when it is empty or its content advances this cycle. Otherwise it holds all registers.
- in_ready = !S1.valid | S1 advances.
- sum_ready = !norm_valid | norm_ready.
- in_ready and sum_ready depend combinationally on ctl_ready and norm_ready only (no path from in_valid or sum_valid).

## Timing
- Reset: every valid, in_ready and sum_ready, and every data output is 0 in the cycle after rst is sampled high.
  - in_ready and sum_ready go to 1 the first cycle after rst deasserts.
- rst mid-operation drops all in-flight transactions. No output is produced for them.
- Latency:
  - Operand accepted at edge k → ctl_valid at edge k+2 when not stalled.
  - Sum accepted at edge k → norm_valid at edge k+1.
- Throughput: 1 per cycle on each path when ctl_ready and norm_ready are held at 1.
- While ctl_valid=1 and ctl_ready=0, the ctl outputs stay stable.
- Capacity under stall: S1 fills, then in_ready falls at most one cycle after S2 stalls. Nothing is lost and nothing is duplicated.
- Simultaneous drain and fill in the same cycle does not insert a bubble.
- The two paths are independent; there is no ordering between ctl and norm results.

## Test plan
- a=0x3FC00000, b=0x3FA00000, add → swap=0, rshift=0, eff_sub=0, sign=0, zero=0, ctl_valid at edge k+2.
- a=0x3F800000, b=0x40000000, sub → swap=1, rshift=1, eff_sub=1, sign=1, zero=0.
- a=b=0x40400000, sub → zero=1, sign=0. Also a=0x60000000 (exp 192), b=0x3F800000 (exp 127), add → rshift=26 (saturated).
- Stream 6 operand sets back-to-back. Hold ctl_ready=0 for cycles 2–5 → in_ready low from the cycle after S1 fills. All 6 results emerge in order, with stable outputs during the stall.
- Sums 0x1000000 → norm_right=1, lz=0. 0x0800000 → lz=0. 0x0000001 → lz=23. 0x0000000 → sum_zero=1, lz=0. Each result appears one cycle after acceptance; norm_ready=0 holds the result.
- Assert rst for one cycle with both pipes full → all valids 0 next cycle, no stale results afterwards, and the next accepted operand produces a correct result.
